// File: rtl/mtrx_elementwise_alu.sv
// mtrx_elementwise_alu
// Multi-cycle element-wise ALU for ROWS x COLS unsigned matrices.
// Supports add, subtract, reverse subtract and max. LANES elements are
// computed per cycle. Overflow is sticky for the whole operation.
// Optional build macro: MTRX_SATURATE_EN. When it is defined, add and
// subtract clamp their results instead of wrapping.
module mtrx_elementwise_alu #(
   parameter int ROWS  = 5,
   parameter int COLS  = 5,
   parameter int WIDTH = 8,
   parameter int LANES = 5
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [1:0]                  op,
   input  logic [ROWS*COLS*WIDTH-1:0]  a,
   input  logic [ROWS*COLS*WIDTH-1:0]  b,
   output logic [ROWS*COLS*WIDTH-1:0]  c,
   output logic                        busy,
   output logic                        done,
   output logic                        overflow
);

   localparam int E  = ROWS * COLS;
   localparam int N  = (E + LANES - 1) / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int VW = E * WIDTH;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              accept_s;
   logic              last_s;

   logic [VW-1:0]     a_r;
   logic [VW-1:0]     b_r;
   logic [VW-1:0]     c_r;
   logic [VW-1:0]     c_next_s;
   logic [1:0]        op_r;
   logic [CW-1:0]     chunk_r;
   logic              busy_r;
   logic              done_r;
   logic              ovf_r;
   logic              ovf_chunk_s;
   logic [31:0]       lane_idx_s;
   logic [WIDTH:0]    lane_res_s;

   // Result of one element: {overflow flag, WIDTH-bit value}.
   // The flag reports carry (add) or borrow (subtracts) whether or not
   // the value is clamped.
   function automatic logic [WIDTH:0] elem_op(input logic [1:0]       sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] res;
      logic             flag;
      sum  = {1'b0, x} + {1'b0, y};
      res  = sum[WIDTH-1:0];
      flag = 1'b0;
      case (sel)
         2'b00: begin
            flag = sum[WIDTH];
`ifdef MTRX_SATURATE_EN
            res  = flag ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
            res  = sum[WIDTH-1:0];
`endif
         end
         2'b01: begin
            flag = (y > x);
`ifdef MTRX_SATURATE_EN
            res  = flag ? {WIDTH{1'b0}} : (x - y);
`else
            res  = x - y;
`endif
         end
         2'b10: begin
            flag = (x > y);
`ifdef MTRX_SATURATE_EN
            res  = flag ? {WIDTH{1'b0}} : (y - x);
`else
            res  = y - x;
`endif
         end
         2'b11: begin
            flag = 1'b0;
            res  = (x > y) ? x : y;
         end
         default: begin
            flag = 1'b0;
            res  = {WIDTH{1'b0}};
         end
      endcase
      return {flag, res};
   endfunction

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: accept a start in IDLE, leave RUN after the last chunk.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      last_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               accept_s     = 1'b1;
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (chunk_r == CW'(N - 1)) begin
               last_s       = 1'b1;
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Lane datapath: compute the current chunk and merge it into the result image.
   // Lanes that fall past the last element leave the result untouched.
   always_comb begin
      c_next_s    = c_r;
      ovf_chunk_s = 1'b0;
      lane_idx_s  = 32'd0;
      lane_res_s  = {(WIDTH+1){1'b0}};
      for (int l = 0; l < LANES; l++) begin
         lane_idx_s = 32'(chunk_r) * 32'(LANES) + 32'(l);
         if (lane_idx_s < 32'(E)) begin
            lane_res_s = elem_op(op_r,
                                 a_r[lane_idx_s*WIDTH +: WIDTH],
                                 b_r[lane_idx_s*WIDTH +: WIDTH]);
            c_next_s[lane_idx_s*WIDTH +: WIDTH] = lane_res_s[WIDTH-1:0];
            ovf_chunk_s = ovf_chunk_s | lane_res_s[WIDTH];
         end else begin
            lane_res_s = {(WIDTH+1){1'b0}};
         end
      end
   end

   // Operand capture, chunk sequencing, result and status registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_r     <= {VW{1'b0}};
         b_r     <= {VW{1'b0}};
         c_r     <= {VW{1'b0}};
         op_r    <= 2'b00;
         chunk_r <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  a_r     <= a;
                  b_r     <= b;
                  op_r    <= op;
                  ovf_r   <= 1'b0;
                  chunk_r <= {CW{1'b0}};
                  busy_r  <= 1'b1;
               end
            end
            ST_RUN: begin
               c_r   <= c_next_s;
               ovf_r <= ovf_r | ovf_chunk_s;
               if (last_s) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  chunk_r <= {CW{1'b0}};
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  chunk_r <= chunk_r + CW'(1);
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               chunk_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign c        = c_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = ovf_r;

endmodule
